// File: rtl/incr_arb_pkg.sv
// Shared constants for the shared-incrementor arbiter: FSM encoding and default sizing.
package incr_arb_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/incr_share_arb_incrementor.sv
// Incrementor: combinational A + 1 with carry out of the top bit.
module Incrementor #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] sum,
    output logic             carryOut
);

    assign {carryOut, sum} = {1'b0, A} + {{WIDTH{1'b0}}, 1'b1};

endmodule

// File: rtl/incr_share_arb.sv
// Round-robin arbiter granting NUM_REQ requesters access to one shared incrementor;
// each transaction walks IDLE -> CALC -> RESP and waits in RESP for the consumer.
module incr_share_arb
    import incr_arb_pkg::*;
#(
    parameter int  NUM_REQ = DEF_NUM_REQ,
    parameter int  WIDTH   = DEF_WIDTH,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_carry,
    input  logic                     rsp_ready,
    output logic                     busy
);

    arb_state_e         state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;

    logic [NUM_REQ-1:0] grant_oh;
    logic [ID_W-1:0]    grant_id;
    logic [WIDTH-1:0]   inc_sum;
    logic               inc_carry;

    // First valid requester at or after ptr, scanning upward with wrap.
    function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                    input logic [ID_W-1:0]    ptr);
        logic [NUM_REQ-1:0] oh;
        logic               found;
        int                 idx;
        logic [ID_W-1:0]    ix;
        oh    = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            ix = ID_W'(idx);
            if (!found && valid[ix]) begin
                oh[ix] = 1'b1;
                found  = 1'b1;
            end
        end
        return oh;
    endfunction

    always_comb begin
        grant_oh = rr_pick(req_valid, rr_ptr_q);
        grant_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) grant_id = ID_W'(i);
        end
    end

    Incrementor #(.WIDTH(WIDTH)) u_inc (
        .A        (opnd_q),
        .sum      (inc_sum),
        .carryOut (inc_carry)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            opnd_q   <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            opnd_q   <= opnd_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        opnd_d   = opnd_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    id_d = grant_id;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (grant_oh[i]) opnd_d = req_data[i*WIDTH +: WIDTH];
                    end
                    state_d = CALC;
                end
            end
            CALC: begin
                sum_d   = inc_sum;
                carry_d = inc_carry;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d  = IDLE;
                    rr_ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant is suppressed while reset is asserted so reset wins over a pending request.
    always_comb begin
        req_ready = (rst_n && state_q == IDLE) ? grant_oh : '0;
        rsp_valid = (state_q == RESP);
        busy      = (state_q != IDLE);
        rsp_id    = id_q;
        rsp_sum   = sum_q;
        rsp_carry = carry_q;
    end

endmodule

// File: tb/tb_incr_share_arb.sv
// Bench for incr_share_arb: directed scenarios plus random traffic against a transaction-level model.
module tb_incr_share_arb;

    localparam int N   = 4;
    localparam int W   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_sum;
    logic           rsp_carry;
    logic           rsp_ready;
    logic           busy;

    always #5 clk = ~clk;

    incr_share_arb #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: one transaction in flight at most; age counts edges since its grant.
    bit m_known = 1'b0;
    bit m_out   = 1'b0;
    int m_ptr   = 0;
    int m_age   = 0;
    int m_id    = 0;
    int m_data  = 0;
    int last_g  = -1;

    int glog_id[$];
    int glog_cyc[$];

    bit         pend[N];
    logic [W-1:0] pdata[N];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        logic [N-1:0] exp_rdy;
        bit           exp_rv;
        int           g;
        int           s;
        int           idx;
        @(negedge clk);
        exp_rdy = '0;
        g       = -1;
        exp_rv  = m_out && (m_age >= 2);
        if (rst_n && m_known && !m_out) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        if (m_known) begin
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            chk("busy", 32'(busy), 32'(m_out));
            if (exp_rv) begin
                s = m_data + 1;
                chk("rsp_id", 32'(rsp_id), 32'(m_id));
                chk("rsp_sum", 32'(rsp_sum), 32'(s % 16));
                chk("rsp_carry", 32'(rsp_carry), 32'(s / 16));
            end
        end
        if (req_ready != '0) begin
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) glog_id.push_back(i);
            end
            glog_cyc.push_back(cyc);
        end
        last_g = -1;
        if (!rst_n) begin
            m_known = 1'b1;
            m_out   = 1'b0;
            m_ptr   = 0;
        end else if (m_known) begin
            if (m_out) begin
                if (exp_rv && rsp_ready) begin
                    m_out = 1'b0;
                    m_ptr = (m_id + 1) % N;
                end else begin
                    m_age++;
                end
            end else if (g >= 0) begin
                m_out  = 1'b1;
                m_age  = 1;
                m_id   = g;
                m_data = int'((req_data >> (g * W)) & 16'hF);
                last_g = g;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] v);
        req_data[i*W +: W] = v;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_data  = 16'h0;
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            pend[i]  = 1'b0;
            pdata[i] = '0;
        end

        // Reset held two cycles with every requester valid
        tick();
        tick();
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_sum", 32'(rsp_sum), 32'd0);
        chk("rst_rsp_carry", 32'(rsp_carry), 32'd0);

        // Single request from requester 2, operand 7
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        req_data  = 16'h3A15;
        set_req(2, 4'h7);
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b0000;
        repeat (3) tick();

        // Wrap: operand F from requester 0
        set_req(0, 4'hF);
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        repeat (3) tick();

        // Fairness from a fresh pointer
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_data  = 16'h9C42;
        tick();
        rst_n = 1'b1;
        glog_id.delete();
        glog_cyc.delete();
        repeat (15) tick();
        chk("fair_cnt", 32'(glog_id.size() >= 5), 32'd1);
        for (int k = 0; k < 5 && k < glog_id.size(); k++) begin
            chk("fair_id", 32'(glog_id[k]), 32'(k % N));
            if (k > 0) chk("fair_gap", 32'(glog_cyc[k] - glog_cyc[k-1]), 32'd3);
        end

        // Backpressure: five stalled cycles in RESP while others request
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        repeat (3) tick();
        rsp_ready = 1'b0;
        set_req(1, 4'h5);
        req_valid = 4'b0010;
        tick();
        req_valid = 4'hF;
        repeat (6) tick();
        rsp_ready = 1'b1;
        tick();
        chk("bp_idle", 32'(busy), 32'd0);
        req_valid = 4'b0000;
        repeat (4) tick();

        // Reset during CALC drops the transaction
        req_valid = 4'b1000;
        tick();
        req_valid = 4'b0000;
        rst_n     = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        glog_id.delete();
        glog_cyc.delete();
        req_valid = 4'hF;
        tick();
        chk("rst_grant_cnt", 32'(glog_id.size()), 32'd1);
        if (glog_id.size() > 0) chk("rst_grant_id", 32'(glog_id[0]), 32'd0);
        req_valid = 4'b0000;
        repeat (3) tick();

        // Random traffic with drops, stalls and occasional reset
        for (int t = 0; t < 2000; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]  = 1'b1;
                    pdata[i] = W'($urandom);
                end else if (pend[i] && $urandom_range(0, 15) == 0) begin
                    pend[i] = 1'b0;
                end
                req_valid[i] = pend[i];
                set_req(i, pdata[i]);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 199) != 0);
            tick();
            if (last_g >= 0) pend[last_g] = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
